// File: rtl/accum4bit.sv
// accum4bit: folds N_SAMPLES 4-bit operands (each with a carry-in) into a running
// sum through the upstream 4-bit adder, then offers the result over a valid/ready port.

module fulladd4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module accum4bit #(
  parameter int N_SAMPLES = 4,
  parameter int CNT_W     = 4,
  parameter bit SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       sum,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic [3:0]       add_s;
  logic             add_c;
  logic             accept;
  logic             last;

  // The adder always sees the current accumulator; its result is only kept on an accept.
  fulladd4 u_add (
    .a    (sum),
    .b    (in_data),
    .cin  (in_cin),
    .s    (add_s),
    .cout (add_c)
  );

  assign accept = (state == ACCUM) && in_valid;
  assign last   = (count == LAST_IDX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)           state_nxt = ACCUM;
      ACCUM:   if (accept && last)  state_nxt = DONE;
      DONE:    if (out_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum        <= 4'h0;
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
      count      <= '0;
    end else if (state == IDLE && start) begin
      sum        <= 4'h0;
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
      count      <= '0;
    end else if (accept) begin
      sum   <= (SATURATE && add_c) ? 4'hF : add_s;
      count <= count + CNT_ONE;
      if (add_c) begin
        ovf_sticky <= 1'b1;
        if (ovf_count != '1) ovf_count <= ovf_count + CNT_ONE;
      end
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_accum4bit.sv
// Self-checking bench for accum4bit: a wrapping and a saturating instance share one
// stimulus stream and are compared against a transaction-level arithmetic model.

module tb_accum4bit;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic       in_cin = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready   [2];
  logic       out_valid  [2];
  logic [3:0] sum        [2];
  logic       ovf_sticky [2];
  logic [3:0] ovf_count  [2];
  logic       busy       [2];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: 0=idle, 1=accumulating, 2=result offered
  int m_state;
  int m_n;
  int m_acc    [2];
  int m_ovf    [2];
  bit m_sticky [2];

  always #5 clk = ~clk;

  accum4bit #(.N_SAMPLES(N), .CNT_W(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_data(in_data), .in_cin(in_cin), .out_valid(out_valid[0]), .out_ready(out_ready),
    .sum(sum[0]), .ovf_sticky(ovf_sticky[0]), .ovf_count(ovf_count[0]), .busy(busy[0])
  );

  accum4bit #(.N_SAMPLES(N), .CNT_W(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_data(in_data), .in_cin(in_cin), .out_valid(out_valid[1]), .out_ready(out_ready),
    .sum(sum[1]), .ovf_sticky(ovf_sticky[1]), .ovf_count(ovf_count[1]), .busy(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s/d%0d in_ready", tag, k),   in_ready[k],   32'(m_state == 1));
      check($sformatf("%s/d%0d out_valid", tag, k),  out_valid[k],  32'(m_state == 2));
      check($sformatf("%s/d%0d busy", tag, k),       busy[k],       32'(m_state != 0));
      check($sformatf("%s/d%0d sum", tag, k),        sum[k],        m_acc[k]);
      check($sformatf("%s/d%0d ovf_sticky", tag, k), ovf_sticky[k], 32'(m_sticky[k]));
      check($sformatf("%s/d%0d ovf_count", tag, k),  ovf_count[k],  m_ovf[k]);
    end
  endtask

  task automatic model_clear();
    m_n = 0;
    for (int k = 0; k < 2; k++) begin
      m_acc[k]    = 0;
      m_ovf[k]    = 0;
      m_sticky[k] = 1'b0;
    end
  endtask

  task automatic model_accept(input int d, input int c);
    for (int k = 0; k < 2; k++) begin
      int t;
      t = m_acc[k] + d + c;
      if (t > 15) begin
        m_sticky[k] = 1'b1;
        if (m_ovf[k] < 15) m_ovf[k]++;
        t = (k == 1) ? 15 : t - 16;
      end
      m_acc[k] = t;
    end
    m_n++;
    if (m_n == N) m_state = 2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_state = 0;
    model_clear();
    check_all(tag);
  endtask

  task automatic start_run(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    if (m_state == 0) begin
      m_state = 1;
      model_clear();
    end
    check_all(tag);
  endtask

  task automatic accept(input string tag, input logic [3:0] d, input logic c);
    in_valid = 1'b1;
    in_data  = d;
    in_cin   = c;
    step();
    in_valid = 1'b0;
    model_accept(int'(d), int'(c));
    check_all(tag);
  endtask

  task automatic wait_cycles(input string tag, input int g);
    for (int i = 0; i < g; i++) begin
      in_data = 4'($urandom);
      step();
      check_all(tag);
    end
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    if (m_state == 2) m_state = 0;
    check_all(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_state = 0;
    model_clear();

    // reset state
    do_reset("reset");

    // directed stream, wrapping and saturating side by side
    start_run("tp1 start");
    accept("tp1 a0", 4'b1010, 1'b1);
    check("tp1 step0 wrap", sum[0], 4'b1011);
    accept("tp1 a1", 4'b0000, 1'b0);
    accept("tp1 a2", 4'b0111, 1'b1);
    check("tp1 step2 wrap", sum[0], 4'b0011);
    check("tp1 step2 sat", sum[1], 4'b1111);
    accept("tp1 a3", 4'b0001, 1'b0);
    check("tp1 final wrap sum", sum[0], 4'b0100);
    check("tp1 final wrap ovf_count", ovf_count[0], 4'd1);
    check("tp1 final sat sum", sum[1], 4'hF);
    check("tp1 final sat ovf_count", ovf_count[1], 4'd2);
    check("tp1 out_valid after last accept", out_valid[0], 1'b1);

    // backpressure in DONE while in_valid and start toggle
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      start    = ~i[0];
      in_data  = 4'($urandom);
      in_cin   = 1'($urandom);
      step();
      check_all($sformatf("bp%0d", i));
    end
    in_valid = 1'b0;
    start    = 1'b0;
    drain("bp release");
    check("bp idle out_valid", out_valid[0], 1'b0);
    check("bp result held", sum[0], 4'b0100);

    // operands with idle gaps between them
    start_run("gap start");
    for (int i = 1; i <= 4; i++) begin
      wait_cycles($sformatf("gap idle%0d", i), 2);
      accept($sformatf("gap a%0d", i), 4'(i), 1'b0);
    end
    check("gap final sum", sum[0], 4'b1010);
    check("gap final sticky", ovf_sticky[0], 1'b0);
    check("gap final ovf_count", ovf_count[0], 4'd0);
    drain("gap drain");

    // reset after two accepts, then an independent run
    start_run("mr start");
    accept("mr a0", 4'hF, 1'b1);
    accept("mr a1", 4'h9, 1'b0);
    do_reset("mr reset");
    check("mr sum cleared", sum[0], 4'h0);
    check("mr in_ready low", in_ready[0], 1'b0);
    start_run("mr restart");
    for (int i = 0; i < N; i++) accept($sformatf("mr r%0d", i), 4'($urandom), 1'($urandom));

    // start together with out_ready in DONE returns to IDLE only
    start     = 1'b1;
    out_ready = 1'b1;
    step();
    start     = 1'b0;
    out_ready = 1'b0;
    m_state   = 0;
    check_all("so idle");
    start_run("so restart");
    check("so sum cleared", sum[0], 4'h0);
    for (int i = 0; i < N; i++) accept($sformatf("so a%0d", i), 4'($urandom), 1'($urandom));
    drain("so drain");

    // randomized runs with random input gaps and output backpressure
    for (int r = 0; r < 30; r++) begin
      start_run($sformatf("rnd%0d start", r));
      for (int i = 0; i < N; i++) begin
        wait_cycles($sformatf("rnd%0d gap%0d", r, i), int'($urandom_range(0, 2)));
        accept($sformatf("rnd%0d a%0d", r, i), 4'($urandom), 1'($urandom));
      end
      wait_cycles($sformatf("rnd%0d hold", r), int'($urandom_range(0, 3)));
      drain($sformatf("rnd%0d drain", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/accum4bit.md
Name: accum4bit

Overview:
- Sequential accumulator directly downstream of the 4-bit full adder stage. It consumes the adder's 4-bit sum and carry/overflow output.
- Collects a fixed-length stream of 4-bit operands through a valid/ready handshake and folds each into a running 4-bit sum: acc + in_data + in_cin.
- Presents the final sum with overflow status through an output valid/ready handshake.
- The implementation instantiates the existing 4-bit full adder with a=acc, b=in_data, Cin=in_cin, and registers its result.

Parameters:
- N_SAMPLES, 4, number of operands accumulated per run; legal range 1..(2^CNT_W)-1.
- CNT_W, 4, width of the sample counter and of ovf_count.
- SATURATE, 0, when 1 the accumulator clamps to 4'hF on carry-out; when 0 it wraps modulo 16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a new run; honoured only in IDLE.
- in_valid  input  1  operand present on in_data/in_cin.
- in_ready  output  1  block accepts an operand this cycle.
- in_data  input  4  operand, unsigned.
- in_cin  input  1  carry-in added with the operand.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- sum  output  4  running/final accumulator value.
- ovf_sticky  output  1  set if any accumulation in this run produced carry-out.
- ovf_count  output  CNT_W  number of accumulations in this run that produced carry-out.
- busy  output  1  high in ACCUM and DONE.

Behaviour:
- Reset (clk edge with rst=1): state=IDLE; sum=0, ovf_sticky=0, ovf_count=0, sample count=0; in_ready=0, out_valid=0, busy=0. Reset overrides every other input, including mid-ACCUM and mid-DONE.
- States:
  - IDLE: in_ready=0, out_valid=0. When start=1, clear sum, ovf_sticky, ovf_count and count, then go to ACCUM. The previous result is held in IDLE until the next start.
  - ACCUM: in_ready=1. An accept occurs when in_valid&in_ready.
    - On accept, compute {c,s5} = acc + in_data + in_cin as a 5-bit value.
    - sum <= s5[3:0], or 4'hF if SATURATE=1 and c=1.
    - If c=1: ovf_sticky <= 1 and ovf_count <= ovf_count+1, saturating at all-ones.
    - count <= count+1.
    - On the accept where count==N_SAMPLES-1, go to DONE.
    - No accept means no state change.
  - DONE: in_ready=0, out_valid=1; sum, ovf_sticky and ovf_count are stable. When out_ready=1, go to IDLE (out_valid low the next cycle).
- start is ignored in ACCUM and DONE, including when start and out_ready are both high in DONE.
- Latency:
  - sum reflects an accepted operand one cycle after the accept edge.
  - out_valid rises one cycle after the last accept.
  - Minimum run length is N_SAMPLES+2 cycles from start to return to IDLE.
- Carry uses unsigned 4-bit semantics: carry-out of bit 3, identical to the adder's overflow output.
- Outputs are registered or decoded from the registered state only; there is no combinational path from in_valid or out_ready to any output.

Test Plan:
- N_SAMPLES=4, SATURATE=0: start, then operands (1010,cin1), (0000,0), (0111,1), (0001,0) -> sum steps 1011, 1011, 0011, 0100. Final sum=4'b0100, ovf_sticky=1, ovf_count=1, out_valid high the cycle after the 4th accept.
- Same stream with SATURATE=1 -> steps 1011, 1011, 1111, 1111. Final sum=4'hF, ovf_count=2, ovf_sticky=1.
- Operands 1,2,3,4 with cin=0 and in_valid gaps of 2 idle cycles between them -> count advances only on accepts. sum=4'b1010, ovf_sticky=0, ovf_count=0.
- Backpressure: in DONE hold out_ready=0 for 5 cycles while pulsing in_valid and start -> out_valid=1 and sum stable, in_ready=0, no accepts. Raising out_ready -> IDLE next cycle with out_valid=0.
- Reset mid-run: rst=1 after 2 accepts -> next cycle state IDLE, sum=0, ovf_sticky=0, ovf_count=0, in_ready=0. A fresh start with 4 operands gives a correct independent result.
- In DONE with start=1 and out_ready=1 together -> go to IDLE only, no new run. start the following cycle -> ACCUM, with sum cleared to 0.
